// File: rtl/eth_10g_tx_pause_ctrl_if.sv
// Pause-request stream in and pause-frame req/ack out of the TX pause scheduler.
interface eth_10g_tx_pause_ctrl_if;
   logic        in_valid;
   logic [15:0] in_data;
   logic        pause_req;
   logic [15:0] pause_quanta;
   logic        pause_ack;

   modport master (output in_valid, in_data, pause_ack,
                   input  pause_req, pause_quanta);
   modport slave  (input  in_valid, in_data, pause_ack,
                   output pause_req, pause_quanta);
endinterface

// File: rtl/eth_10g_tx_pause_ctrl.sv
// TX flow-control scheduler: turns pause-quanta requests into pause-frame
// insertion requests and refreshes XOFF before the far-end timer runs out.
module eth_10g_tx_pause_ctrl #(
   parameter int REFRESH_SHIFT = 2,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   eth_10g_tx_pause_ctrl_if.slave bus,
   output logic                 xoff_active,
   output logic [CNT_WIDTH-1:0] req_count
);
   localparam int RW = 16 + REFRESH_SHIFT;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] REQ       = 2'd1;
   localparam logic [1:0] XOFF_WAIT = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 req_q, req_d;
   logic [15:0]          quanta_q, quanta_d;
   logic                 pend_vld_q, pend_vld_d;
   logic [15:0]          pend_q, pend_d;
   logic                 xoff_q, xoff_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [RW-1:0]        rcnt_q, rcnt_d;

   logic          hs;
   logic [RW-1:0] interval;

   assign hs       = req_q & bus.pause_ack;
   assign interval = RW'(quanta_q) << REFRESH_SHIFT;

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      quanta_d   = quanta_q;
      pend_vld_d = pend_vld_q;
      pend_d     = pend_q;
      xoff_d     = xoff_q;
      cnt_d      = cnt_q;
      rcnt_d     = rcnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               quanta_d = bus.in_data;
               req_d    = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (hs) begin
               cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
               xoff_d = (quanta_q != 16'd0);
               if (bus.in_valid || pend_vld_q) begin
                  quanta_d   = bus.in_valid ? bus.in_data : pend_q;
                  pend_vld_d = 1'b0;
               end else if (quanta_q != 16'd0) begin
                  // A one-cycle interval means the refresh is due immediately,
                  // so the request simply stays up.
                  if (interval != RW'(1)) begin
                     req_d   = 1'b0;
                     state_d = XOFF_WAIT;
                     rcnt_d  = interval - RW'(1);
                  end
               end else begin
                  req_d   = 1'b0;
                  state_d = IDLE;
               end
            end else if (bus.in_valid) begin
               pend_vld_d = 1'b1;
               pend_d     = bus.in_data;
            end
         end
         XOFF_WAIT: begin
            if (bus.in_valid) begin
               quanta_d = bus.in_data;
               req_d    = 1'b1;
               state_d  = REQ;
            end else if (rcnt_q <= RW'(1)) begin
               req_d   = 1'b1;
               state_d = REQ;
            end else begin
               rcnt_d = rcnt_q - RW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         quanta_q   <= 16'd0;
         pend_vld_q <= 1'b0;
         pend_q     <= 16'd0;
         xoff_q     <= 1'b0;
         cnt_q      <= '0;
         rcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         quanta_q   <= quanta_d;
         pend_vld_q <= pend_vld_d;
         pend_q     <= pend_d;
         xoff_q     <= xoff_d;
         cnt_q      <= cnt_d;
         rcnt_q     <= rcnt_d;
      end
   end

   assign bus.pause_req    = req_q;
   assign bus.pause_quanta = quanta_q;
   assign xoff_active      = xoff_q;
   assign req_count        = cnt_q;
endmodule

// File: tb/tb_eth_10g_tx_pause_ctrl.sv
// Randomized scoreboard bench for eth_10g_tx_pause_ctrl against a
// transaction-level model using absolute refresh deadlines.
module tb_eth_10g_tx_pause_ctrl;
   localparam int RS   = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   eth_10g_tx_pause_ctrl_if bus();
   logic          xoff_active;
   logic [CW-1:0] req_count;

   eth_10g_tx_pause_ctrl #(.REFRESH_SHIFT(RS), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .xoff_active (xoff_active),
      .req_count   (req_count)
   );

   typedef struct {
      int unsigned cyc;
      logic [15:0] q;
      int unsigned cnt;
      bit          xoff;
   } hs_t;

   hs_t         sb[$];
   int unsigned cyc = 0;
   int          n_pass = 0, n_tot = 0, mis = 0;

   // model state
   bit          m_req = 0, m_wait = 0, m_xoff = 0, m_pv = 0;
   logic [15:0] m_q = 0, m_pd = 0;
   int unsigned m_cnt = 0, m_deadline = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Reference model: requests, one pending slot, and a refresh deadline in absolute cycles.
   initial begin
      bit v, a;
      logic [15:0] d;
      int unsigned c;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_req = 0; m_wait = 0; m_xoff = 0; m_pv = 0;
            m_q = 0; m_pd = 0; m_cnt = 0; m_deadline = 0;
            sb.delete();
         end else begin
            c = cyc; v = bus.in_valid; d = bus.in_data; a = bus.pause_ack;
            if (m_req && a) begin
               sb.push_back('{c, m_q, m_cnt, m_xoff});
               if (m_cnt < CMAX) m_cnt++;
               m_xoff = (m_q != 0);
               if (v || m_pv) begin
                  m_q = v ? d : m_pd;
                  m_pv = 0;
               end else begin
                  m_req = 0;
                  if (m_q != 0) begin
                     m_wait = 1;
                     m_deadline = c + (int'(m_q) << RS);
                  end
               end
            end else if (m_req) begin
               if (v) begin m_pv = 1; m_pd = d; end
            end else if (v) begin
               m_wait = 0; m_req = 1; m_q = d;
            end
            if (m_wait && c + 1 >= m_deadline) begin
               m_wait = 0; m_req = 1;
            end
            cyc++;
         end
      end
   end

   // Monitor: every DUT handshake is matched against the scoreboard.
   initial begin
      hs_t e;
      int unsigned sc;
      logic [15:0] sq;
      int unsigned scnt;
      bit sx;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (bus.pause_req !== m_req || (m_req && bus.pause_quanta !== m_q)) mis++;
            if (bus.pause_req && bus.pause_ack) begin
               sc = cyc; sq = bus.pause_quanta; scnt = req_count; sx = xoff_active;
               @(posedge clk);
               #2;
               chk("hs_expected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("hs_cycle", sc, e.cyc);
                  chk("hs_quanta", sq, e.q);
                  chk("hs_req_count", scnt, e.cnt);
                  chk("hs_xoff", sx, e.xoff);
               end
            end
         end
      end
   end

   task automatic step(input bit v, input logic [15:0] d, input bit a);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.pause_ack = a;
   endtask

   task automatic idle(input int n, input bit a);
      for (int i = 0; i < n; i++) step(1'b0, 16'd0, a);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pause_req"}, bus.pause_req, 0);
      chk({tag, "_pause_quanta"}, bus.pause_quanta, 0);
      chk({tag, "_xoff"}, xoff_active, 0);
      chk({tag, "_req_count"}, req_count, 0);
   endtask

   task automatic async_reset(input string tag);
      bus.pause_ack = 1'b0;
      bus.in_valid  = 1'b0;
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_zero(tag);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      bus.in_valid = 0; bus.in_data = 0; bus.pause_ack = 0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // XOFF 0x0010, ack 3 cycles later, refresh 64 cycles after the ack
      step(1, 16'h0010, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
      idle(70, 1);
      // XON preempts the wait; afterwards nothing for 1000 cycles despite ack noise
      step(1, 16'h0000, 0); step(0, 0, 1); idle(4, 0);
      chk("xoff_after_xon", xoff_active, 0);
      for (int i = 0; i < 1000; i++) step(0, 0, ($urandom % 4) == 0);

      // pending overwrite: 0x0020 dropped in favour of 0x0030
      step(1, 16'h0100, 0); step(1, 16'h0020, 0); step(1, 16'h0030, 0);
      step(0, 0, 0); step(0, 0, 1); step(0, 0, 1); idle(5, 0);

      // new beat coincident with ack; refresh interval of 20 afterwards
      step(1, 16'h0100, 0); step(0, 0, 0); step(1, 16'h0005, 1); idle(30, 1);
      step(1, 16'h0000, 0); step(0, 0, 1); idle(3, 0);

      // long stall with ack low
      step(1, 16'h0077, 0); idle(500, 0); step(0, 0, 1); idle(3, 0);

      // reset mid-XOFF_WAIT, then mid-REQ, then a fresh request from IDLE
      step(1, 16'h0040, 0); step(0, 0, 1); idle(5, 0);
      async_reset("rst_wait");
      step(1, 16'h0033, 0); step(0, 0, 0);
      async_reset("rst_req");
      step(1, 16'h0007, 0); step(0, 0, 1); idle(3, 0);
      chk("post_reset_count", req_count, 1);

      for (int i = 0; i < 4000; i++)
         step(($urandom % 100) < 6, (($urandom % 5) == 0) ? 16'd0 : 16'($urandom_range(1, 12)),
              ($urandom % 100) < 35);
      for (int i = 0; i < 2000; i++)
         step(($urandom % 100) < 30, (($urandom % 4) == 0) ? 16'd0 : 16'($urandom_range(1, 3)),
              ($urandom % 100) < 50);
      idle(4, 0);
      @(negedge clk);

      chk("req_count_sat", req_count, CMAX);
      chk("final_req_count", req_count, m_cnt);
      chk("final_xoff", xoff_active, m_xoff);
      chk("sb_drained", sb.size(), 0);
      chk("req_quanta_trace", mis, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
